// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer: FSM encoding and counter sizing.
package serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dff_bank_sr.sv
// WIDTH-bit D flip-flop bank with sync clear, parallel load and zero-fill shift toward the output end.
// Priority is clear > load > shift; q_out is the bit currently sitting at the output end.
module dff_bank_sr #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_out
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
    end
  end

  assign q_out = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/shift_serializer.sv
// Loads a WIDTH-bit word on start and presents it one bit per clock on s_out; first bit appears the cycle after accept.
// No backpressure: start is only honoured in IDLE/DONE, so DONE+start gives back-to-back words every WIDTH+1 cycles.
module shift_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         d_in,
  output logic                     s_out,
  output logic                     busy,
  output logic                     done,
  output logic [cnt_w(WIDTH)-1:0]  bit_cnt
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_t state;
  logic   accept;
  logic   sr_clr;
  logic   sr_shift;

  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign sr_shift = (state == ST_SHIFT);
  // The stray 2'b11 encoding also wipes the register so IDLE always shows s_out=0.
  assign sr_clr   = reset || !(state inside {ST_IDLE, ST_SHIFT, ST_DONE});

  // The final SHIFT edge shifts once more, leaving sr all-zero so s_out drops to 0 in DONE.
  dff_bank_sr #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk   (clk),
    .reset (sr_clr),
    .load  (accept),
    .shift (sr_shift),
    .d     (d_in),
    .q_out (s_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_SHIFT;
            busy    <= 1'b1;
            bit_cnt <= CNT_ONE;
          end else begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == CNT_MAX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
